// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame check for the PS/2 keyboard decoder
// Purpose: scan-code set 2 prefix/shift codes, frame geometry, ASCII control
//          values and the 11-bit frame validity check.
// Ports:   none (package).
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT     = 8'h12;
  localparam logic [7:0] PS2_RSHIFT     = 8'h59;

  localparam int PS2_FRAME_LEN = 11;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_TAB   = 8'h09;

  // Frame bit 0 is start, 8:1 data, 9 parity, 10 stop. Data plus parity
  // must carry an odd number of ones.
  function automatic logic ps2_frame_ok(input logic [10:0] frame);
    return !frame[0] && frame[10] && (^frame[9:1]);
  endfunction

endpackage

// File: rtl/ps2_keyboard_decoder.sv
// rtl/ps2_keyboard_decoder.sv - PS/2 keyboard receiver with set-2 make/break decoding
// Purpose: synchronizes and glitch-filters the PS/2 lines, deframes 11-bit
//          device-to-host frames, decodes E0/F0 prefixes and translates the
//          final code to ASCII through ps2_scan_to_ascii.
// Ports (ps2_scan_to_ascii):
//   code_i   in  8  scan code byte
//   ext_i    in  1  code was preceded by E0 (forces 0x00)
//   shift_i  in  1  a shift key is held
//   ascii_o  out 8  ASCII value, 0x00 when unmapped
// Ports (ps2_keyboard_decoder):
//   clk, reset                      system clock, synchronous active-high reset
//   ps2_clk_async, ps2_data_async   raw PS/2 pins
//   scan_code, ascii_code           last make/break byte and its ASCII value
//   key_pressed                     held-key level
//   key_released                    one-clk pulse on a completed break sequence
// Config: define PS2_SHIFT_EN to track left/right shift and emit shifted ASCII.

module ps2_scan_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_i,
  input  logic       shift_i,
  output logic [7:0] ascii_o
);

  logic [7:0] letter;
  logic [7:0] digit_plain;
  logic [7:0] digit_shift;
  logic [7:0] ctrl;

  always_comb begin
    letter      = '0;
    digit_plain = '0;
    digit_shift = '0;
    ctrl        = '0;
    case (code_i)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      8'h45: begin digit_plain = "0"; digit_shift = ")"; end
      8'h16: begin digit_plain = "1"; digit_shift = "!"; end
      8'h1E: begin digit_plain = "2"; digit_shift = "@"; end
      8'h26: begin digit_plain = "3"; digit_shift = "#"; end
      8'h25: begin digit_plain = "4"; digit_shift = "$"; end
      8'h2E: begin digit_plain = "5"; digit_shift = "%"; end
      8'h36: begin digit_plain = "6"; digit_shift = "^"; end
      8'h3D: begin digit_plain = "7"; digit_shift = "&"; end
      8'h3E: begin digit_plain = "8"; digit_shift = "*"; end
      8'h46: begin digit_plain = "9"; digit_shift = "("; end
      8'h29: ctrl = ASCII_SPACE;
      8'h5A: ctrl = ASCII_CR;
      8'h66: ctrl = ASCII_BS;
      8'h76: ctrl = ASCII_ESC;
      8'h0D: ctrl = ASCII_TAB;
      default: ;
    endcase

    if (ext_i)                 ascii_o = '0;
    else if (letter != '0)     ascii_o = shift_i ? (letter - 8'h20) : letter;
    else if (digit_plain != '0) ascii_o = shift_i ? digit_shift : digit_plain;
    else                       ascii_o = ctrl;
  end

endmodule

module ps2_keyboard_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic       key_pressed,
  output logic       key_released
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Input synchronizers, reset to the idle-high line level.
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic clk_s, data_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_async};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_async};
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Glitch filter: the filtered level flips only after FILTER_LEN
  // consecutive samples disagree with it.
  logic [FW-1:0] filt_cnt_q;
  logic          filt_q, filt_prev_q, fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // Deframer and mid-frame timeout.
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   shreg_q, shreg_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          frame_done, frame_ok;
  logic [7:0]    rx_byte;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    timer_d    = timer_q;
    frame_done = 1'b0;
    if (fall) begin
      shreg_d = {data_s, shreg_q[10:1]};
      timer_d = '0;
      if (bit_cnt_q == 4'(PS2_FRAME_LEN - 1)) begin
        frame_done = 1'b1;
        bit_cnt_d  = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != '0) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = '0;
        shreg_d   = '0;
        timer_d   = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  assign rx_byte  = shreg_d[8:1];
  assign frame_ok = ps2_frame_ok(shreg_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      timer_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      timer_q   <= timer_d;
    end
  end

  // Prefix tracking and output decode.
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [7:0] held_q, held_d, scan_q, scan_d, ascii_q, ascii_d;
  logic       pressed_q, pressed_d, released_q, released_d;
  logic       shift_held, is_shift;
  logic [7:0] map_ascii;

`ifdef PS2_SHIFT_EN
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  assign shift_held = lshift_q | rshift_q;
  // E0-prefixed 0x12 is part of Print Screen, not a shift key.
  assign is_shift   = !ext_q && (rx_byte == PS2_LSHIFT || rx_byte == PS2_RSHIFT);
`else
  assign shift_held = 1'b0;
  assign is_shift   = 1'b0;
`endif

  ps2_scan_to_ascii u_map (
    .code_i  (rx_byte),
    .ext_i   (ext_q),
    .shift_i (shift_held),
    .ascii_o (map_ascii)
  );

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    held_d     = held_q;
    scan_d     = scan_q;
    ascii_d    = ascii_q;
    pressed_d  = pressed_q;
    released_d = 1'b0;
`ifdef PS2_SHIFT_EN
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
`endif
    if (frame_done) begin
      if (!frame_ok) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (rx_byte == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d  = 1'b0;
        brk_d  = 1'b0;
        scan_d = rx_byte;
        if (is_shift) begin
          ascii_d = '0;
`ifdef PS2_SHIFT_EN
          if (rx_byte == PS2_LSHIFT) lshift_d = !brk_q;
          else                       rshift_d = !brk_q;
`endif
        end else if (!brk_q) begin
          ascii_d   = map_ascii;
          pressed_d = 1'b1;
          held_d    = rx_byte;
        end else begin
          // Only the break of the most recently made key drops the level.
          released_d = 1'b1;
          if (rx_byte == held_q) pressed_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      held_q     <= '0;
      scan_q     <= '0;
      ascii_q    <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
`ifdef PS2_SHIFT_EN
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
`endif
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      held_q     <= held_d;
      scan_q     <= scan_d;
      ascii_q    <= ascii_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
`ifdef PS2_SHIFT_EN
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
`endif
    end
  end

  assign scan_code    = scan_q;
  assign ascii_code   = ascii_q;
  assign key_pressed  = pressed_q;
  assign key_released = released_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// tb/tb_ps2_keyboard_decoder.sv - self-checking bench for ps2_keyboard_decoder
module tb_ps2_keyboard_decoder;

  localparam int TIMEOUT = 2000;
  localparam int HALF    = 40;
  localparam int GAP     = 100;
`ifdef PS2_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  localparam logic [7:0] LETTER_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code, ascii_code;
  logic       key_pressed, key_released;

  int checks = 0;
  int errors = 0;
  int rel_cnt = 0;
  int rel_seen = 0;

  // Reference state
  logic [7:0] m_scan, m_ascii, m_held;
  bit         m_pressed, m_ext, m_brk, m_lsh, m_rsh;
  int         m_rel;

  ps2_keyboard_decoder #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_clk_async  (ps2_clk),
    .ps2_data_async (ps2_data),
    .scan_code      (scan_code),
    .ascii_code     (ascii_code),
    .key_pressed    (key_pressed),
    .key_released   (key_released)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (key_released === 1'b1) rel_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit shift);
    string sh = ")!@#$%^&*(";
    for (int i = 0; i < 26; i++)
      if (c == LETTER_CODES[i]) return shift ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (c == DIGIT_CODES[i]) return shift ? 8'(sh[i]) : 8'(8'h30 + i);
    case (c)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h76: return 8'h1B;
      8'h0D: return 8'h09;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_scan = 0; m_ascii = 0; m_held = 0; m_pressed = 0;
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_rel = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    m_rel = 0;
    if (!ok) begin
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      m_scan = b;
      if (SHIFT_EN && !m_ext && (b == 8'h12 || b == 8'h59)) begin
        m_ascii = 0;
        if (b == 8'h12) m_lsh = !m_brk; else m_rsh = !m_brk;
      end else if (!m_brk) begin
        m_ascii   = m_ext ? 8'h00 : ref_ascii(b, m_lsh || m_rsh);
        m_pressed = 1;
        m_held    = b;
      end else begin
        m_rel = 1;
        if (b == m_held) m_pressed = 0;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      if (glitch && i == 3) begin
        repeat (15) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 18) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".scan"}, 32'(scan_code), 32'(m_scan));
    check({tag, ".ascii"}, 32'(ascii_code), 32'(m_ascii));
    check({tag, ".pressed"}, 32'(key_pressed), 32'(m_pressed));
    check({tag, ".rel_pulses"}, 32'(rel_cnt - rel_seen), 32'(m_rel));
    rel_seen = rel_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch, input string tag);
    send_bits(mk_frame(b, bad_par), 11, glitch);
    repeat (GAP) @(negedge clk);
    model_byte(b, !bad_par);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rel_seen = rel_cnt;
  endtask

  initial begin
    logic [7:0] code;
    int         r;

    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");

    // Make, break, bad parity
    send_byte(8'h1C, 0, 0, "make_1c");
    send_byte(8'hF0, 0, 0, "brk_pfx");
    send_byte(8'h1C, 0, 0, "brk_1c");
    send_byte(8'h1C, 1, 0, "bad_parity");

    // Partial frame then timeout; next frame must align
    send_bits(mk_frame(8'h00, 0), 5, 0);
    repeat (2 * TIMEOUT) @(negedge clk);
    send_byte(8'h29, 0, 0, "after_timeout");

    // Extended key make and break
    send_byte(8'hE0, 0, 0, "ext_pfx");
    send_byte(8'h75, 0, 0, "ext_make");
    send_byte(8'hE0, 0, 0, "ext_pfx2");
    send_byte(8'hF0, 0, 0, "ext_brk_pfx");
    send_byte(8'h75, 0, 0, "ext_brk");

    // Overlapping keys and typematic repeat
    send_byte(8'h32, 0, 1, "make_b");
    send_byte(8'h32, 0, 0, "repeat_b");
    send_byte(8'h21, 0, 0, "make_c");
    send_byte(8'hF0, 0, 0, "brk_pfx_b");
    send_byte(8'h32, 0, 0, "brk_old_b");

`ifdef PS2_SHIFT_EN
    send_byte(8'h12, 0, 0, "lshift_make");
    send_byte(8'h1C, 0, 0, "shift_a");
    send_byte(8'h16, 0, 0, "shift_1");
    send_byte(8'hF0, 0, 0, "lshift_brk_pfx");
    send_byte(8'h12, 0, 0, "lshift_brk");
    send_byte(8'h1C, 0, 0, "unshift_a");
`endif

    // Randomized byte stream against the reference model
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      code = 8'hE0;
      else if (r <= 2) code = 8'hF0;
      else if (r <= 6) begin
        r = int'($urandom_range(0, 35));
        code = (r < 26) ? LETTER_CODES[r] : DIGIT_CODES[r - 26];
      end
      else if (r == 7) code = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
      else             code = 8'($urandom);
      send_byte(code, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), "random");
    end

    // Reset in the middle of a frame
    send_bits(mk_frame(8'h1C, 0), 6, 0);
    do_reset();
    check_all("mid_reset");
    repeat (2 * TIMEOUT) @(negedge clk);
    check_all("mid_reset_idle");
    send_byte(8'h5A, 0, 0, "post_reset_make");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
